// File: rtl/nf10_encap_multi_if.sv
// AXI4-Stream bundle used on both sides of nf10_encap_multi.
//   tdata  : beat payload, byte k at [8k+7:8k]
//   tstrb  : byte enables, contiguous from byte 0
//   tuser  : sideband, carries the 16-bit packet length field
//   tvalid / tready : handshake
//   tlast  : final beat of a packet
interface nf10_encap_multi_if #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned UserWidth = 128
) ();
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tstrb;
  logic [UserWidth-1:0]   tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_encap_multi.sv
// Packet encapsulation stage: per packet, either prepends a HDR_BYTES header taken from the
// descriptor or forwards the packet untouched. Output is a single register slice.
//   axi_aclk, axi_reset     : clock, asynchronous active-high reset
//   s_axis (slave)          : input stream
//   m_axis (master)         : registered output stream
//   desc_valid/ready/encap  : per-packet descriptor, consumed with input beat 0
//   desc_hdr                : header, byte 0 in [7:0] goes out first
//   encap_count/pass_count  : completed packet counters, wrapping
module nf10_encap_multi #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned HDR_BYTES          = 34,
  parameter int unsigned TOTAL_LENGTH_POS   = 0
) (
  input  logic                   axi_aclk,
  input  logic                   axi_reset,
  nf10_encap_multi_if.slave      s_axis,
  nf10_encap_multi_if.master     m_axis,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic                   desc_encap,
  input  logic [8*HDR_BYTES-1:0] desc_hdr,
  output logic [31:0]            encap_count,
  output logic [31:0]            pass_count
);
  localparam int W      = int'(C_AXIS_DATA_WIDTH);
  localparam int U      = int'(C_AXIS_TUSER_WIDTH);
  localparam int Bytes  = W / 8;
  localparam int H      = int'(HDR_BYTES);
  // H < 2*Bytes, so there is at most one full header beat.
  localparam int Nh     = H / Bytes;
  localparam int R      = H % Bytes;
  localparam int LenPos = int'(TOTAL_LENGTH_POS);

  typedef enum logic [2:0] {StIdle, StPass, StHdr, StShift, StTail} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   carry_q, carry_d;
  logic [Bytes-1:0] tail_strb_q, tail_strb_d;
  // Input beat 0 is parked here while the full header beat goes out.
  logic [W-1:0]   hold_data_q, hold_data_d;
  logic [Bytes-1:0] hold_strb_q, hold_strb_d;
  logic           hold_last_q, hold_last_d;
  logic [31:0]    encap_q, encap_d, pass_q, pass_d;

  logic           m_valid_q, m_last_q;
  logic [W-1:0]   m_data_q;
  logic [Bytes-1:0] m_strb_q;
  logic [U-1:0]   m_user_q;

  logic           out_valid, out_last, do_shift;
  logic [W-1:0]   out_data;
  logic [Bytes-1:0] out_strb;
  logic [U-1:0]   out_user, tuser_mod;

  logic           load, s_ready, s_fire;
  logic [2*W-1:0] desc_pad;

  logic [W-1:0]   src_carry, src_data, sh_data, sh_carry;
  logic [Bytes-1:0] src_strb, sh_strb, sh_tail_strb;
  logic           src_last, sh_tail;

  assign desc_pad = {{(2*W-8*H){1'b0}}, desc_hdr};
  assign load     = ~m_valid_q | m_axis.tready;
  assign s_ready  = ~axi_reset & load &
                    (((state_q == StIdle) & desc_valid) | (state_q == StPass) |
                     (state_q == StShift));
  assign s_fire   = s_axis.tvalid & s_ready;
  assign desc_ready = s_fire & (state_q == StIdle);
  assign s_axis.tready = s_ready;

  // Shift source: live input, or the parked beat 0 when leaving the header beat.
  always_comb begin
    src_carry = carry_q;
    src_data  = s_axis.tdata;
    src_strb  = s_axis.tstrb;
    src_last  = s_axis.tlast;
    if (state_q == StIdle) begin
      src_carry = desc_pad[Nh*W +: W];
    end else if (state_q == StHdr) begin
      src_data = hold_data_q;
      src_strb = hold_strb_q;
      src_last = hold_last_q;
    end
  end

  // R carried bytes in the low lanes, input shifted up by R; top R input bytes carry over.
  always_comb begin
    sh_data      = '0;
    sh_strb      = '0;
    sh_carry     = '0;
    sh_tail_strb = '0;
    for (int b = 0; b < Bytes; b++) begin
      if (b < R) begin
        sh_data[8*b +: 8] = src_carry[8*b +: 8];
        sh_strb[b]        = 1'b1;
      end else begin
        sh_data[8*b +: 8] = src_data[8*(b-R) +: 8];
        sh_strb[b]        = src_strb[b-R];
      end
    end
    for (int j = 0; j < R; j++) begin
      sh_carry[8*j +: 8] = src_data[8*(Bytes-R+j) +: 8];
      sh_tail_strb[j]    = src_strb[Bytes-R+j];
    end
  end

  assign sh_tail = src_last & (|sh_tail_strb);

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    tail_strb_d = tail_strb_q;
    hold_data_d = hold_data_q;
    hold_strb_d = hold_strb_q;
    hold_last_d = hold_last_q;
    encap_d     = encap_q;
    pass_d      = pass_q;
    out_valid   = 1'b0;
    out_data    = '0;
    out_strb    = '0;
    out_user    = '0;
    out_last    = 1'b0;
    do_shift    = 1'b0;
    tuser_mod   = s_axis.tuser;
    tuser_mod[LenPos +: 16] = s_axis.tuser[LenPos +: 16] + 16'(H);

    unique case (state_q)
      StIdle: begin
        if (s_fire) begin
          if (desc_encap) begin
            out_user = tuser_mod;
            if (Nh > 0) begin
              out_valid   = 1'b1;
              out_data    = desc_pad[W-1:0];
              out_strb    = '1;
              carry_d     = desc_pad[Nh*W +: W];
              hold_data_d = s_axis.tdata;
              hold_strb_d = s_axis.tstrb;
              hold_last_d = s_axis.tlast;
              state_d     = StHdr;
            end else begin
              do_shift = 1'b1;
            end
          end else begin
            out_valid = 1'b1;
            out_data  = s_axis.tdata;
            out_strb  = s_axis.tstrb;
            out_user  = s_axis.tuser;
            out_last  = s_axis.tlast;
            if (s_axis.tlast) pass_d = pass_q + 32'd1;
            else              state_d = StPass;
          end
        end
      end
      StPass: begin
        if (s_fire) begin
          out_valid = 1'b1;
          out_data  = s_axis.tdata;
          out_strb  = s_axis.tstrb;
          out_user  = s_axis.tuser;
          out_last  = s_axis.tlast;
          if (s_axis.tlast) begin
            pass_d  = pass_q + 32'd1;
            state_d = StIdle;
          end
        end
      end
      StHdr:   do_shift = load;
      StShift: do_shift = s_fire;
      StTail: begin
        if (load) begin
          out_valid = 1'b1;
          out_data  = carry_q;
          out_strb  = tail_strb_q;
          out_last  = 1'b1;
          encap_d   = encap_q + 32'd1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_shift) begin
      out_valid = 1'b1;
      out_data  = sh_data;
      out_strb  = sh_strb;
      out_last  = src_last & ~sh_tail;
      carry_d   = sh_carry;
      if (!src_last) begin
        state_d = StShift;
      end else if (sh_tail) begin
        tail_strb_d = sh_tail_strb;
        state_d     = StTail;
      end else begin
        encap_d = encap_q + 32'd1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= StIdle;
      carry_q     <= '0;
      tail_strb_q <= '0;
      hold_data_q <= '0;
      hold_strb_q <= '0;
      hold_last_q <= 1'b0;
      encap_q     <= '0;
      pass_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_strb_q    <= '0;
      m_user_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      tail_strb_q <= tail_strb_d;
      hold_data_q <= hold_data_d;
      hold_strb_q <= hold_strb_d;
      hold_last_q <= hold_last_d;
      encap_q     <= encap_d;
      pass_q      <= pass_d;
      if (load) begin
        m_valid_q <= out_valid;
        m_data_q  <= out_data;
        m_strb_q  <= out_strb;
        m_user_q  <= out_user;
        m_last_q  <= out_last;
      end
    end
  end

  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tstrb  = m_strb_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tlast  = m_last_q;
  assign encap_count   = encap_q;
  assign pass_count    = pass_q;
endmodule

// File: doc/nf10_encap_multi.md
# nf10_encap_multi

Parametrised packet-encapsulation stage for the AXI4-Stream datapath. For each packet it either prepends a per-packet header of HDR_BYTES bytes or passes the packet through unchanged. Data width and header length are generic, and the header may be longer than one data beat. The header and the encap/pass decision arrive on a per-packet descriptor handshake. The block sits between the output-port lookup and the output queues, and it exports packet counters for status registers.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256: data width W, a multiple of 64 in the range 64..512; BYTES = W/8.
- C_AXIS_TUSER_WIDTH, 128: tuser width.
- HDR_BYTES, 34: header length H, in the range 1..2*BYTES-1; NH = H / BYTES, R = H mod BYTES.
- TOTAL_LENGTH_POS, 0: LSB of the 16-bit packet-length field in tuser.

Ports:
- axi_aclk  in  1  the block's single clock; all logic is clocked on its rising edge.
- axi_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata / tstrb / tuser / tvalid / tready / tlast  in/in/in/in/out/in  W/BYTES/C_AXIS_TUSER_WIDTH/1/1/1  input stream; tstrb is contiguous from byte 0.
- desc_valid  in  1  descriptor present.
- desc_ready  out  1  descriptor consumed.
- desc_encap  in  1  1 = prepend header, 0 = pass through.
- desc_hdr  in  8*H  header; byte 0 is [7:0] and is transmitted first.
- m_axis_tdata / tstrb / tuser / tvalid / tready / tlast  out/out/out/out/in/out  same widths as input  output stream, registered.
- encap_count  out  32  number of encapsulated packets completed; wraps.
- pass_count  out  32  number of passthrough packets completed; wraps.

## Operation
- **Byte order**: byte k of a beat is tdata[8k+7:8k]. The output stream is the header bytes 0..H-1 followed by the packet bytes.
- **IDLE**:
  - The first input beat is accepted only together with the descriptor: desc_ready = s_axis_tvalid & s_axis_tready & desc_valid.
  - If desc_encap=1, capture desc_hdr and go to HDR (when NH>0) or SHIFT (when NH=0).
  - If desc_encap=0, go to PASS.
- **PASS**: forward each beat unchanged. On tlast: return to IDLE and increment pass_count.
- **HDR**:
  - Emit NH full-header beats: tstrb all ones, tlast=0.
  - s_axis_tready=0 during header beats that do not merge input data.
- **SHIFT**:
  - Each output beat = the R carried bytes in its low bytes, followed by input bytes 0..BYTES-R-1.
  - Input bytes BYTES-R..BYTES-1 become the new carry.
  - The first carry is header bytes NH*BYTES..H-1.
  - If R=0, beats pass unshifted after the header.
- **Last input beat** (n valid bytes):
  - If n+R <= BYTES: emit one beat with tstrb = (n+R) low ones and tlast=1, then return to IDLE.
  - Otherwise: emit a full beat with tlast=0, go to TAIL, and s_axis_tready=0.
- **TAIL**: emit the n+R-BYTES carried bytes with tlast=1. Return to IDLE and increment encap_count; encap_count is incremented at this same point for the no-TAIL case.
- **tuser**:
  - The first output beat of an encapsulated packet carries the tuser of input beat 0, with its length field increased by H, modulo 2^16.
  - All later beats of an encapsulated packet carry tuser = 0.
  - Passthrough packets keep tuser unchanged.
- **Packet boundaries**: no bubbles between packets are required; a new descriptor may be taken in the cycle after the last output beat is loaded.

## Timing
- **Output register slice**: m_axis_* is loaded whenever the slice is empty or m_axis_tready=1. Latency from input handshake to m_axis_tvalid is 1 cycle.
- **Throughput**: 1 beat/cycle with no back-pressure. Encapsulation adds NH cycles, plus 1 cycle when a TAIL beat is needed.
- **Input ready**: s_axis_tready = (slice free or m_axis_tready) & state not in {HDR, TAIL}; in IDLE it additionally requires desc_valid.
- **AXI-Stream rule**: m_axis_* holds stable while tvalid=1 and tready=0.
- **Reset**:
  - On axi_reset: every output is 0, state is IDLE, the carry and both counters clear, and desc_ready=0.
  - Reset applies immediately, without waiting for a clock edge.
  - A packet in flight is discarded; no partial tlast is generated.
- **Counters**: 32-bit, wrap from 0xFFFFFFFF to 0.

## Test plan
- **Encap, 64-byte packet** (W=256, H=34, hdr bytes 0x01..0x22): expect 4 output beats.
  - Beat 0 = header bytes 0..31.
  - Beat 1 = 0x21,0x22 followed by input bytes 0..29.
  - Beat 2 = input bytes 30..61.
  - Beat 3 = input bytes 62,63 with tstrb=0x3, tlast=1.
  - tuser length 64 -> 98; encap_count=1.
- **Encap, 62-byte packet**: exactly 3 beats; the last beat has tstrb all ones and tlast=1; no TAIL beat.
- **Passthrough, 60-byte packet**: 2 beats, bit-identical to the input including tuser; pass_count=1.
- **Random m_axis_tready (50%)** with back-to-back 1500-byte packets of mixed encap/pass: byte-exact output stream, no drops, tdata stable while stalled.
- **axi_reset asserted mid-packet**: all outputs are 0 immediately; the next packet after reset deassertion is correct; counters read 0.
- **W=64, H=14** (NH=1, R=6), 60-byte encapsulated packet: 74 bytes in 10 beats; last beat tstrb=0x03, tlast=1; length 60 -> 74.
